// File: rtl/fetch_ctrl_if.sv
// I-cache request/response and IF/ID register bundle for the fetch controller.
// master = fetch side, slave = cache + decode side.
interface fetch_ctrl_if;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic        ICACHE_stall;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_valid;

    modport master (
        output ICACHE_ren, ICACHE_addr, IF_ID_pc, IF_ID_inst, IF_ID_valid,
        input  ICACHE_rdata, ICACHE_stall
    );
    modport slave (
        input  ICACHE_ren, ICACHE_addr, IF_ID_pc, IF_ID_inst, IF_ID_valid,
        output ICACHE_rdata, ICACHE_stall
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC, I-cache request and IF/ID register.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hazard_stall,
    input  logic              hazard_flush,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              mem_stall,
    fetch_ctrl_if.master      bus,
    output logic [31:0]       perf_ic_stall,
    output logic [31:0]       perf_redirect
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n, pend_pc, pend_n;
    logic [31:0] if_pc, if_pc_n, if_inst, if_inst_n;
    logic        if_vld, if_vld_n;
    logic        hold;
    logic [31:0] rtgt;

    assign hold = mem_stall | hazard_stall;
    assign rtgt = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            pend_pc <= '0;
            if_pc   <= '0;
            if_inst <= NOP;
            if_vld  <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            pend_pc <= pend_n;
            if_pc   <= if_pc_n;
            if_inst <= if_inst_n;
            if_vld  <= if_vld_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        pend_n    = pend_pc;
        if_pc_n   = if_pc;
        if_inst_n = if_inst;
        if_vld_n  = if_vld;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: if (!hold) begin
                if (bus.ICACHE_stall) begin
                    if_inst_n = NOP;
                    if_vld_n  = 1'b0;
                    if (redirect_valid) begin
                        pend_n  = rtgt;
                        state_n = DROP;
                    end
                // a flush only matters alongside a redirect, which already bubbles
                end else if (redirect_valid || (hazard_flush && redirect_valid)) begin
                    pc_n      = rtgt;
                    if_inst_n = NOP;
                    if_vld_n  = 1'b0;
                end else begin
                    if_pc_n   = pc;
                    if_inst_n = bus.ICACHE_rdata;
                    if_vld_n  = 1'b1;
                    pc_n      = pc + 32'd4;
                end
            end
            DROP: if (!hold) begin
                if_inst_n = NOP;
                if_vld_n  = 1'b0;
                if (redirect_valid) pend_n = rtgt;
                // stale cache data is discarded; resume at the newest target
                if (!bus.ICACHE_stall) begin
                    pc_n    = redirect_valid ? rtgt : pend_pc;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ICACHE_ren  = (state != IDLE);
    assign bus.ICACHE_addr = pc[31:2];
    assign bus.IF_ID_pc    = if_pc;
    assign bus.IF_ID_inst  = if_inst;
    assign bus.IF_ID_valid = if_vld;

`ifdef FETCH_PERF_CNT_EN
    logic ic_inc, rd_inc;
    assign ic_inc = (state != IDLE) && bus.ICACHE_stall;
    assign rd_inc = (state != IDLE) && redirect_valid && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ic_stall <= '0;
            perf_redirect <= '0;
        end else begin
            if (ic_inc && perf_ic_stall != 32'hFFFF_FFFF) perf_ic_stall <= perf_ic_stall + 32'd1;
            if (rd_inc && perf_redirect != 32'hFFFF_FFFF) perf_redirect <= perf_redirect + 32'd1;
        end
    end
`else
    assign perf_ic_stall = '0;
    assign perf_redirect = '0;
`endif
endmodule
